// File: rtl/text_line_renderer.sv
// -----------------------------------------------------------------------------
// text_line_renderer
//
// Renders one 16-character line of text at a fixed screen origin. The current
// pixel position is mapped to a character cell. The cell index goes out on
// char_xy, and the returned char_code plus the glyph row form the font ROM
// address. The font row that comes back is then sampled at the pixel's bit
// column to give a registered text-on bit and colour.
//
// The pipeline is free-running, with no valid/ready handshake. One pixel enters
// every clk, and its result appears on text_on/text_rgb exactly 3 clks later.
// The sync generator must delay hsync/vsync by the same amount.
//
// Optional feature: define TEXT_LINE_BLINK_EN to blink the text. The text is
// visible for 2^BLINK_LOG2 frames and then blank for 2^BLINK_LOG2 frames.
//
// Ports:
//   clk        in   1   pixel clock
//   reset      in   1   synchronous, active-high
//   video_on   in   1   visible-area flag
//   pixel_x    in  10   current pixel column
//   pixel_y    in  10   current pixel row
//   frame_tick in   1   one pulse per frame (blink counter only)
//   char_xy    out  8   char ROM address {4'h0, column}; combinational
//   char_code  in   7   char ROM data, combinational from char_xy
//   font_addr  out 11   font ROM address {char_code, glyph_row}; registered
//   font_data  in   8   font ROM row, one clk after font_addr; bit 7 = leftmost
//   text_on    out  1   pixel is a set glyph bit; registered
//   text_rgb   out 12   FG_RGB when text_on, else 0; registered
// -----------------------------------------------------------------------------
module text_line_renderer #(
   parameter int          X0         = 192,
   parameter int          Y0         = 32,
   parameter int          SCALE_LOG2 = 1,
   parameter logic [11:0] FG_RGB     = 12'hFFF,
   parameter int          BLINK_LOG2 = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        video_on,
   input  logic [9:0]  pixel_x,
   input  logic [9:0]  pixel_y,
   input  logic        frame_tick,
   output logic [7:0]  char_xy,
   input  logic [6:0]  char_code,
   output logic [10:0] font_addr,
   input  logic [7:0]  font_data,
   output logic        text_on,
   output logic [11:0] text_rgb
);

   localparam int W = 128 << SCALE_LOG2;
   localparam int H = 16 << SCALE_LOG2;

   // Stage 0: geometry (combinational)
   logic [9:0]  dx, dy;
   logic [10:0] px, py;
   logic        in_region;
   logic [3:0]  col_idx;
   logic [3:0]  glyph_row;
   logic [2:0]  bit_col;

   assign dx = pixel_x - 10'(X0);
   assign dy = pixel_y - 10'(Y0);

   // The compares are done at 11 bits so that X0+W and Y0+H cannot wrap.
   assign px = {1'b0, pixel_x};
   assign py = {1'b0, pixel_y};
   assign in_region = (px >= 11'(X0)) && (px < 11'(X0 + W)) &&
                      (py >= 11'(Y0)) && (py < 11'(Y0 + H));

   // Left of X0 the index is garbage. That is harmless because in_region
   // masks the result further down the pipe.
   assign col_idx   = 4'(dx >> (3 + SCALE_LOG2));
   assign glyph_row = 4'(dy >> SCALE_LOG2);
   assign bit_col   = 3'(dx >> SCALE_LOG2);
   assign char_xy   = {4'h0, col_idx};

   // Stages 1 and 2: address register plus side-band delay to line up with font_data
   logic [2:0] bit_col_d1, bit_col_d2;
   logic       in_region_d1, in_region_d2;
   logic       video_on_d1, video_on_d2;

   always_ff @(posedge clk) begin
      if (reset) begin
         font_addr    <= '0;
         bit_col_d1   <= '0;
         bit_col_d2   <= '0;
         in_region_d1 <= 1'b0;
         in_region_d2 <= 1'b0;
         video_on_d1  <= 1'b0;
         video_on_d2  <= 1'b0;
      end else begin
         font_addr    <= {char_code, glyph_row};
         bit_col_d1   <= bit_col;
         in_region_d1 <= in_region;
         video_on_d1  <= video_on;
         bit_col_d2   <= bit_col_d1;
         in_region_d2 <= in_region_d1;
         video_on_d2  <= video_on_d1;
      end
   end

   // Blink gate
   logic show;

`ifdef TEXT_LINE_BLINK_EN
   logic [BLINK_LOG2:0] blink_cnt;

   // A frame_tick that arrives with reset is dropped, because reset has priority.
   always_ff @(posedge clk) begin
      if (reset)
         blink_cnt <= '0;
      else if (frame_tick)
         blink_cnt <= blink_cnt + 1'b1;
   end

   assign show = ~blink_cnt[BLINK_LOG2];
`else
   logic unused_frame_tick;
   assign unused_frame_tick = frame_tick;
   assign show = 1'b1;
`endif

   // Stage 3: output register
   logic pix_bit, on_next;

   assign pix_bit = font_data[3'd7 - bit_col_d2];
   assign on_next = video_on_d2 && in_region_d2 && pix_bit && show;

   always_ff @(posedge clk) begin
      if (reset) begin
         text_on  <= 1'b0;
         text_rgb <= 12'h000;
      end else begin
         text_on  <= on_next;
         text_rgb <= on_next ? FG_RGB : 12'h000;
      end
   end

endmodule

// File: tb/tb_text_line_renderer.sv
// -----------------------------------------------------------------------------
// tb_text_line_renderer
//
// Directed bench for text_line_renderer with its default parameters:
// X0=192, Y0=32, SCALE_LOG2=1, FG_RGB=12'hFFF.
//
// Each driven pixel pushes a hand-computed expected text_on into exp_q and an
// expected font_addr into fa_q. The monitor pops and compares whenever the
// matching output is due: font_addr 1 clk after the pixel, text_on/text_rgb
// 3 clks after it.
//
// The font ROM model returns the row chosen for each pixel one clk after
// font_addr. The char ROM model is combinational: column 0 is ' ' (0x20),
// column 5 is 'C' (0x43), and every other column is 0x30+column.
// -----------------------------------------------------------------------------
module tb_text_line_renderer;

   // Clock / reset
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic        video_on = 1'b0;
   logic [9:0]  pixel_x = '0, pixel_y = '0;
   logic        frame_tick = 1'b0;
   logic [7:0]  char_xy;
   logic [6:0]  char_code;
   logic [10:0] font_addr;
   logic [7:0]  font_data = '0;
   logic        text_on;
   logic [11:0] text_rgb;

   text_line_renderer dut (
      .clk        (clk),
      .reset      (reset),
      .video_on   (video_on),
      .pixel_x    (pixel_x),
      .pixel_y    (pixel_y),
      .frame_tick (frame_tick),
      .char_xy    (char_xy),
      .char_code  (char_code),
      .font_addr  (font_addr),
      .font_data  (font_data),
      .text_on    (text_on),
      .text_rgb   (text_rgb)
   );

   // ROM models
   function automatic logic [6:0] char_rom(input logic [3:0] c);
      case (c)
         4'd0:    char_rom = 7'h20;
         4'd5:    char_rom = 7'h43;
         default: char_rom = 7'h30 + {3'b000, c};
      endcase
   endfunction

   assign char_code = char_rom(char_xy[3:0]);

   logic [7:0] font_val = '0;
   logic [7:0] font_val_d1 = '0;
   always @(posedge clk) begin
      font_val_d1 <= font_val;
      font_data   <= font_val_d1;
   end

   // Scoreboard
   logic        exp_q[$];
   logic [11:0] fa_q[$];
   int n_total = 0;
   int n_pass  = 0;
   logic       issued = 1'b0;
   logic [2:0] tag = '0;

   always @(posedge clk) tag <= {tag[1:0], issued};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      else
         n_pass++;
   endtask

   // Monitor
   always @(negedge clk) begin
      logic [11:0] fa;
      logic        e;
      if (tag[0]) begin
         if (fa_q.size() == 0) check("fa_q_underflow", 1, 0);
         else begin
            fa = fa_q.pop_front();
            if (fa[11]) check("font_addr", 32'(font_addr), 32'(fa[10:0]));
         end
      end
      if (tag[2]) begin
         if (exp_q.size() == 0) check("exp_q_underflow", 1, 0);
         else begin
            e = exp_q.pop_front();
            check("text_on", 32'(text_on), 32'(e));
            check("text_rgb", 32'(text_rgb), e ? 32'hFFF : 32'h0);
         end
      end
   end

   // Drivers
   task automatic drive(input logic [9:0] x, input logic [9:0] y, input logic von,
                        input logic [7:0] fd, input logic exp_on,
                        input logic chk_fa, input logic [10:0] exp_fa,
                        input logic chk_cx, input logic [7:0] exp_cx);
      @(negedge clk); #1;
      reset    = 1'b0;
      pixel_x  = x;
      pixel_y  = y;
      video_on = von;
      font_val = fd;
      issued   = 1'b1;
      exp_q.push_back(exp_on);
      fa_q.push_back({chk_fa, exp_fa});
      #1;
      if (chk_cx) check("char_xy", 32'(char_xy), 32'(exp_cx));
   endtask

   // Shorthand for a pixel where only text_on is checked.
   task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic von,
                      input logic [7:0] fd, input logic exp_on);
      drive(x, y, von, fd, exp_on, 1'b0, 11'h0, 1'b0, 8'h0);
   endtask

   // One reset cycle mid-stream. Reset flushes every in-flight result to 0,
   // and font_addr reads 0 after the reset edge.
   task automatic drive_reset(input logic [9:0] x, input logic [9:0] y, input logic [7:0] fd);
      @(negedge clk); #1;
      reset    = 1'b1;
      pixel_x  = x;
      pixel_y  = y;
      video_on = 1'b1;
      font_val = fd;
      issued   = 1'b1;
      foreach (exp_q[i]) exp_q[i] = 1'b0;
      exp_q.push_back(1'b0);
      fa_q.push_back({1'b1, 11'h000});
   endtask

`ifdef TEXT_LINE_BLINK_EN
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk); #1 frame_tick = 1'b1;
         @(negedge clk); #1 frame_tick = 1'b0;
      end
   endtask
`endif

   // Main sequence
   initial begin
      repeat (3) @(negedge clk);
      check("reset_text_on", 32'(text_on), 0);
      check("reset_text_rgb", 32'(text_rgb), 0);
      check("reset_font_addr", 32'(font_addr), 0);

      // Cell / address and bit polarity
      drive(10'd276, 10'd38, 1'b1, 8'h20, 1'b1, 1'b1, 11'h433, 1'b1, 8'h05);
      drive(10'd276, 10'd38, 1'b1, 8'hDF, 1'b0, 1'b1, 11'h433, 1'b1, 8'h05);
      drive(10'd192, 10'd32, 1'b1, 8'h80, 1'b1, 1'b1, 11'h200, 1'b1, 8'h00);
      pix(10'd194, 10'd32, 1'b1, 8'h40, 1'b1);   // bit_col 1
      pix(10'd194, 10'd32, 1'b1, 8'h80, 1'b0);

      // Boundaries with every font bit set
      pix(10'd191, 10'd40, 1'b1, 8'hFF, 1'b0);
      pix(10'd192, 10'd40, 1'b1, 8'hFF, 1'b1);
      drive(10'd447, 10'd40, 1'b1, 8'hFF, 1'b1, 1'b1, 11'h3F4, 1'b1, 8'h0F);
      pix(10'd448, 10'd40, 1'b1, 8'hFF, 1'b0);
      pix(10'd200, 10'd31, 1'b1, 8'hFF, 1'b0);
      pix(10'd200, 10'd32, 1'b1, 8'hFF, 1'b1);
      pix(10'd200, 10'd63, 1'b1, 8'hFF, 1'b1);
      pix(10'd200, 10'd64, 1'b1, 8'hFF, 1'b0);

      // Blanking
      pix(10'd300, 10'd40, 1'b0, 8'hFF, 1'b0);
      pix(10'd300, 10'd40, 1'b1, 8'h00, 1'b0);

      // Reset mid-stream
      for (int i = 0; i < 4; i++) pix(10'd300, 10'd40, 1'b1, 8'hFF, 1'b1);
      drive_reset(10'd300, 10'd40, 8'hFF);
      for (int i = 0; i < 4; i++) pix(10'd300, 10'd40, 1'b1, 8'hFF, 1'b1);

      // Drain
      for (int i = 0; i < 3; i++) pix(10'd0, 10'd0, 1'b0, 8'h00, 1'b0);
      @(negedge clk); #1 issued = 1'b0;
      for (int i = 0; i < 10 && (exp_q.size() != 0 || fa_q.size() != 0); i++)
         @(negedge clk);
      check("drain_exp_q", 32'(exp_q.size()), 0);
      check("drain_fa_q", 32'(fa_q.size()), 0);

`ifdef TEXT_LINE_BLINK_EN
      @(negedge clk); #1;
      pixel_x = 10'd300; pixel_y = 10'd40; video_on = 1'b1; font_val = 8'hFF;
      tick(31);
      repeat (4) @(negedge clk);
      check("blink_31", 32'(text_on), 1);
      tick(1);
      repeat (4) @(negedge clk);
      check("blink_32", 32'(text_on), 0);
      tick(32);
      repeat (4) @(negedge clk);
      check("blink_64", 32'(text_on), 1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
